mpr_ctx_bank: RTL and testbench
===============================

# mpr_ctx_bank

Parametrised multi-context pipeline register bank; successor to the fixed 15-field, single-context MPR used at each inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Holds up to NUM_SLOTS saved stage snapshots, each tagged by thread address.
- Supports save-on-context-switch, tagged restore with registered select to the stage mux, explicit free from the memory controller, and an optional consume-on-restore mode.
- One instance sits beside each pipeline register; restore_sel drives the existing stage mux.

## Interface
- NUM_FIELDS, 15, fields per snapshot
- WIDTH, 32, bits per field
- NUM_SLOTS, 4, saved contexts (≥2)
- TAG_W, 8, thread-address tag width
- CONSUME_ON_RESTORE, 0, 1 = slot freed when restored

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- save_valid  in  1  context switch: capture save_data under save_tag
- save_tag  in  TAG_W  thread address being switched out
- save_data  in  NUM_FIELDS×WIDTH  current stage fields
- restore_req  in  1  request snapshot for restore_tag
- restore_tag  in  TAG_W  thread address being switched in
- free_valid  in  1  memory controller released a thread
- free_tag  in  TAG_W  released thread address
- restore_sel  out  1  one-cycle select to stage mux (snapshot valid)
- restore_data  out  NUM_FIELDS×WIDTH  restored fields
- restore_miss  out  1  one-cycle pulse: request tag not present
- overflow  out  1  one-cycle pulse: save dropped, bank full
- full  out  1  all slots valid
- occupancy  out  $clog2(NUM_SLOTS+1)  valid slot count

## Operation
- Each slot: valid bit, tag, NUM_FIELDS×WIDTH data. Reset clears all valid bits; data is not reset.
- Save: tag hit overwrites that slot's data. On a miss, allocate the lowest-index free slot. If full with a miss, drop the save and pulse overflow; contents stay unchanged.
- Restore: a hit registers the slot data into restore_data and asserts restore_sel for exactly one cycle. A miss pulses restore_miss, restore_sel stays 0, and restore_data holds its previous value.
- CONSUME_ON_RESTORE=1: the hit slot's valid bit clears in the same edge as the restore capture.
- Free: a hit clears valid. A miss is ignored with no flag.
- Tags within valid slots are unique by construction; at most one hit per lookup.
- Simultaneous events on the same tag, same cycle:
  - save + free: save wins. The slot stays or becomes valid with the new data.
  - restore + save: restore returns the pre-save data (read-before-write); the slot then holds the new data and stays valid even if CONSUME_ON_RESTORE=1.
  - restore + free: restore returns the data; the slot is freed.
- Different tags, same cycle: all three operations apply independently.
  - A free in the same cycle does not make its slot available to the save.
  - Same for a consume-on-restore in the same cycle.
  - Overflow is judged on pre-edge occupancy.
- occupancy and full reflect post-edge state, registered.

## Timing
- All outputs registered. Reset values: restore_sel=0, restore_miss=0, overflow=0, full=0, occupancy=0, restore_data=0.
- Save → data restorable from the next cycle.
- restore_req in cycle N → restore_sel/restore_data/restore_miss valid in cycle N+1.
- Back-to-back restores allowed every cycle.
- rst_n low in the cycle of any request: the request is discarded and all outputs take reset values.

## Structure
- Package mpr_pkg holds:
  - field_t (logic [WIDTH-1:0]) and snapshot_t (field_t [NUM_FIELDS-1:0]), with WIDTH and NUM_FIELDS as package defaults.
  - Default TAG_W.
  - Slot record struct {valid, tag}.
- Sub-module mpr_free_slot_enc: parametrised lowest-index priority encoder over the valid vector. Outputs are index and any_free.
- Tag match: flat combinational compare vector, one per slot, reused for save, restore and free.

## Test plan
- Reset, then save tag 0x12 with field0=0xDEADBEEF; restore 0x12 next cycle → restore_sel=1 for one cycle, field0=0xDEADBEEF, occupancy=1.
- Save tags 0x01–0x04 (NUM_SLOTS=4), then save 0x05 → full=1, overflow pulse. Restore 0x05 → restore_miss=1, restore_sel=0.
- Free 0x02, then save 0x05 → allocated in slot 1, full=1, occupancy=4. Restore 0x05 → correct data.
- Same-cycle save 0x07 (data A→B) with restore 0x07 → restore_data=A. A later restore returns B.
- Same-cycle save and free on 0x07 → slot stays valid with the new data, occupancy unchanged.
- CONSUME_ON_RESTORE=1: save 0x09, restore 0x09 → hit and occupancy decrements. Second restore 0x09 → restore_miss=1. Assert rst_n=0 mid-sequence → all outputs zero, occupancy=0.

Source files
------------

// File: rtl/mpr_pkg.sv
// Shared types and defaults for the multi-context pipeline register bank.
// Snapshot shape mirrors one inter-stage pipeline register.
package mpr_pkg;

  localparam int DEF_NUM_FIELDS = 15;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_TAG_W      = 8;
  localparam int DEF_NUM_SLOTS  = 4;

  typedef logic [DEF_WIDTH-1:0] field_t;
  typedef field_t [DEF_NUM_FIELDS-1:0] snapshot_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
  } slot_t;

endpackage

// File: rtl/mpr_ctx_bank_if.sv
// Save/restore/free request bundle and registered status outputs
// between a pipeline stage and its context bank.
interface mpr_ctx_bank_if
  import mpr_pkg::*;
#(
  parameter int NUM_FIELDS = DEF_NUM_FIELDS,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int TAG_W      = DEF_TAG_W
) ();

  localparam int OW = $clog2(NUM_SLOTS + 1);

  logic                             save_valid;
  logic [TAG_W-1:0]                 save_tag;
  logic [NUM_FIELDS-1:0][WIDTH-1:0] save_data;
  logic                             restore_req;
  logic [TAG_W-1:0]                 restore_tag;
  logic                             free_valid;
  logic [TAG_W-1:0]                 free_tag;
  logic                             restore_sel;
  logic [NUM_FIELDS-1:0][WIDTH-1:0] restore_data;
  logic                             restore_miss;
  logic                             overflow;
  logic                             full;
  logic [OW-1:0]                    occupancy;

  modport master (
    output save_valid, save_tag, save_data,
    output restore_req, restore_tag,
    output free_valid, free_tag,
    input  restore_sel, restore_data, restore_miss,
    input  overflow, full, occupancy
  );

  modport slave (
    input  save_valid, save_tag, save_data,
    input  restore_req, restore_tag,
    input  free_valid, free_tag,
    output restore_sel, restore_data, restore_miss,
    output overflow, full, occupancy
  );

endinterface

// File: rtl/mpr_free_slot_enc.sv
// Lowest-index free-slot priority encoder over the slot valid vector.
module mpr_free_slot_enc #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  output logic [IW-1:0] index,
  output logic          any_free
);

  // Scan high to low so the lowest free index is the last one written
  always_comb begin
    index    = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        index    = IW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpr_ctx_bank.sv
// Tagged multi-context snapshot bank beside one pipeline register.
// Restore is read-before-write; save beats free/consume on the same slot.
module mpr_ctx_bank
  import mpr_pkg::*;
#(
  parameter int NUM_FIELDS         = DEF_NUM_FIELDS,
  parameter int WIDTH              = DEF_WIDTH,
  parameter int NUM_SLOTS          = DEF_NUM_SLOTS,
  parameter int TAG_W              = DEF_TAG_W,
  parameter bit CONSUME_ON_RESTORE = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  mpr_ctx_bank_if.slave bus
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam int OW = $clog2(NUM_SLOTS + 1);

  typedef logic [NUM_FIELDS-1:0][WIDTH-1:0] snap_t;

  logic [NUM_SLOTS-1:0] valid;
  logic [NUM_SLOTS-1:0] valid_nx;
  logic [TAG_W-1:0]     tags [NUM_SLOTS];
  snap_t                mem  [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] hit_s;
  logic [NUM_SLOTS-1:0] hit_r;
  logic [NUM_SLOTS-1:0] hit_f;
  logic [NUM_SLOTS-1:0] wr_en;
  logic [NUM_SLOTS-1:0] clr;
  logic [IW-1:0]        free_idx;
  logic                 any_free;
  logic                 s_hit;
  logic                 r_hit;
  logic                 alloc;
  snap_t                rd_data;
  logic [OW-1:0]        occ_nx;

  mpr_free_slot_enc #(
    .N  (NUM_SLOTS),
    .IW (IW)
  ) u_enc (
    .valid    (valid),
    .index    (free_idx),
    .any_free (any_free)
  );

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_s[i] = valid[i] && (tags[i] == bus.save_tag);
      hit_r[i] = valid[i] && (tags[i] == bus.restore_tag);
      hit_f[i] = valid[i] && (tags[i] == bus.free_tag);
    end
  end

  always_comb begin
    s_hit   = |hit_s;
    r_hit   = bus.restore_req && |hit_r;
    alloc   = bus.save_valid && !s_hit && any_free;
    wr_en   = '0;
    clr     = '0;
    rd_data = '0;
    occ_nx  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      wr_en[i] = bus.save_valid &&
                 (hit_s[i] || (alloc && free_idx == IW'(i)));
      clr[i]   = (bus.free_valid && hit_f[i]) ||
                 (CONSUME_ON_RESTORE && bus.restore_req && hit_r[i]);
      if (hit_r[i]) rd_data = rd_data | mem[i];
    end
    // Allocation only targets slots free before the edge, so set after clear
    valid_nx = (valid & ~clr) | wr_en;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occ_nx = occ_nx + OW'(valid_nx[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid            <= '0;
      bus.restore_sel  <= 1'b0;
      bus.restore_miss <= 1'b0;
      bus.restore_data <= '0;
      bus.overflow     <= 1'b0;
      bus.full         <= 1'b0;
      bus.occupancy    <= '0;
    end else begin
      valid            <= valid_nx;
      bus.restore_sel  <= r_hit;
      bus.restore_miss <= bus.restore_req && !(|hit_r);
      if (r_hit) bus.restore_data <= rd_data;
      bus.overflow     <= bus.save_valid && !s_hit && !any_free;
      bus.full         <= &valid_nx;
      bus.occupancy    <= occ_nx;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rst_n && wr_en[i]) begin
        tags[i] <= bus.save_tag;
        mem[i]  <= bus.save_data;
      end
    end
  end

endmodule

// File: tb/tb_mpr_ctx_bank.sv
// Bench for mpr_ctx_bank: plain and consume-on-restore instances share
// stimulus and are scored against a per-tag reference model.
module tb_mpr_ctx_bank;
  import mpr_pkg::*;

  localparam int NF = 15;
  localparam int W  = 32;
  localparam int NS = 4;
  localparam int TW = 8;
  localparam int DW = NF * W;
  localparam int OW = $clog2(NS + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     sv = 1'b0;
  logic [TW-1:0]            st = '0;
  logic [NF-1:0][W-1:0]     sd = '0;
  logic                     rq = 1'b0;
  logic [TW-1:0]            rt = '0;
  logic                     fv = 1'b0;
  logic [TW-1:0]            ft = '0;

  mpr_ctx_bank_if #(.NUM_FIELDS(NF), .WIDTH(W),
    .NUM_SLOTS(NS), .TAG_W(TW)) b0 ();
  mpr_ctx_bank_if #(.NUM_FIELDS(NF), .WIDTH(W),
    .NUM_SLOTS(NS), .TAG_W(TW)) b1 ();

  assign b0.save_valid  = sv;
  assign b0.save_tag    = st;
  assign b0.save_data   = sd;
  assign b0.restore_req = rq;
  assign b0.restore_tag = rt;
  assign b0.free_valid  = fv;
  assign b0.free_tag    = ft;
  assign b1.save_valid  = sv;
  assign b1.save_tag    = st;
  assign b1.save_data   = sd;
  assign b1.restore_req = rq;
  assign b1.restore_tag = rt;
  assign b1.free_valid  = fv;
  assign b1.free_tag    = ft;

  mpr_ctx_bank #(.NUM_FIELDS(NF), .WIDTH(W), .NUM_SLOTS(NS),
    .TAG_W(TW), .CONSUME_ON_RESTORE(1'b0)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  mpr_ctx_bank #(.NUM_FIELDS(NF), .WIDTH(W), .NUM_SLOTS(NS),
    .TAG_W(TW), .CONSUME_ON_RESTORE(1'b1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Reference: which tags are present, and their data, per instance
  bit            pres  [2][256];
  logic [DW-1:0] val   [2][256];
  logic [DW-1:0] e_data[2];
  bit            e_sel [2];
  bit            e_miss[2];
  bit            e_ov  [2];
  int            e_occ [2];

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int  cnt;
      bit  rh;
      bit  sh;
      bit  fh;
      e_sel[m]  = 1'b0;
      e_miss[m] = 1'b0;
      e_ov[m]   = 1'b0;
      if (!rst_n) begin
        for (int t = 0; t < 256; t++) pres[m][t] = 1'b0;
        e_data[m] = '0;
      end else begin
        cnt = 0;
        for (int t = 0; t < 256; t++) cnt += int'(pres[m][t]);
        rh = rq && pres[m][rt];
        sh = sv && pres[m][st];
        fh = fv && pres[m][ft];
        if (rq) begin
          if (rh) begin
            e_sel[m]  = 1'b1;
            e_data[m] = val[m][rt];
          end else begin
            e_miss[m] = 1'b1;
          end
        end
        if (fh && !(sv && st == ft)) pres[m][ft] = 1'b0;
        if (m == 1 && rh && !(sv && st == rt)) pres[m][rt] = 1'b0;
        if (sv) begin
          if (sh || cnt < NS) begin
            pres[m][st] = 1'b1;
            val[m][st]  = sd;
          end else begin
            e_ov[m] = 1'b1;
          end
        end
      end
      e_occ[m] = 0;
      for (int t = 0; t < 256; t++) e_occ[m] += int'(pres[m][t]);
    end
  endtask

  task automatic chk_unit(input int m, input logic sel,
                          input logic miss, input logic ov,
                          input logic [OW-1:0] occ, input logic fl,
                          input logic [DW-1:0] data);
    chk($sformatf("u%0d.sel", m), DW'(sel), DW'(e_sel[m]));
    chk($sformatf("u%0d.miss", m), DW'(miss), DW'(e_miss[m]));
    chk($sformatf("u%0d.ovf", m), DW'(ov), DW'(e_ov[m]));
    chk($sformatf("u%0d.occ", m), DW'(occ), DW'(e_occ[m]));
    chk($sformatf("u%0d.full", m), DW'(fl), DW'(e_occ[m] == NS));
    chk($sformatf("u%0d.data", m), data, e_data[m]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_unit(0, b0.restore_sel, b0.restore_miss, b0.overflow,
             b0.occupancy, b0.full, b0.restore_data);
    chk_unit(1, b1.restore_sel, b1.restore_miss, b1.overflow,
             b1.occupancy, b1.full, b1.restore_data);
  endtask

  task automatic idle();
    sv = 1'b0;
    rq = 1'b0;
    fv = 1'b0;
  endtask

  task automatic rnd_data(input logic [W-1:0] f0);
    for (int f = 0; f < NF; f++) sd[f] = $urandom;
    sd[0] = f0;
  endtask

  task automatic save(input logic [TW-1:0] t, input logic [W-1:0] f0);
    sv = 1'b1;
    st = t;
    rnd_data(f0);
  endtask

  task automatic restore(input logic [TW-1:0] t);
    rq = 1'b1;
    rt = t;
  endtask

  task automatic free(input logic [TW-1:0] t);
    fv = 1'b1;
    ft = t;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) e_data[m] = '0;
    do_reset();
    step();

    // Basic save then restore
    idle(); save(8'h12, 32'hDEADBEEF); step();
    idle(); restore(8'h12); step();
    chk("basic.f0", DW'(b0.restore_data[0]), DW'(32'hDEADBEEF));
    chk("basic.sel", DW'(b0.restore_sel), DW'(1'b1));
    chk("basic.occ", DW'(b0.occupancy), DW'(1));
    idle(); step();
    chk("basic.sel_drop", DW'(b0.restore_sel), DW'(1'b0));

    // Fill, overflow, miss, free and reallocate
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      idle(); save(TW'(t), 32'h100 + t); step();
    end
    idle(); save(8'h05, 32'h5555); step();
    chk("fill.ovf", DW'(b0.overflow), DW'(1'b1));
    chk("fill.full", DW'(b0.full), DW'(1'b1));
    idle(); restore(8'h05); step();
    chk("fill.miss", DW'(b0.restore_miss), DW'(1'b1));
    idle(); free(8'h02); step();
    idle(); save(8'h05, 32'h5AA5); step();
    chk("realloc.occ", DW'(b0.occupancy), DW'(4));
    idle(); restore(8'h05); step();
    chk("realloc.f0", DW'(b0.restore_data[0]), DW'(32'h5AA5));

    // Read-before-write on same-tag save and restore
    do_reset();
    idle(); save(8'h07, 32'hAAAA0001); step();
    idle(); save(8'h07, 32'hBBBB0002); restore(8'h07); step();
    chk("rbw.old", DW'(b0.restore_data[0]), DW'(32'hAAAA0001));
    idle(); restore(8'h07); step();
    chk("rbw.new", DW'(b0.restore_data[0]), DW'(32'hBBBB0002));

    // Save beats free on the same tag
    idle(); save(8'h07, 32'hCCCC0003); free(8'h07); step();
    idle(); restore(8'h07); step();
    chk("savefree.f0", DW'(b0.restore_data[0]), DW'(32'hCCCC0003));

    // Consume-on-restore, then reset mid-sequence
    do_reset();
    idle(); save(8'h09, 32'h99); step();
    idle(); restore(8'h09); step();
    chk("cons.occ", DW'(b1.occupancy), DW'(0));
    idle(); restore(8'h09); step();
    chk("cons.miss", DW'(b1.restore_miss), DW'(1'b1));
    idle(); save(8'h09, 32'h98); step();
    rst_n = 1'b0;
    idle(); restore(8'h09); save(8'h0A, 32'h1); step();
    rst_n = 1'b1;
    chk("rst.sel", DW'(b0.restore_sel), DW'(1'b0));
    chk("rst.data", b0.restore_data, DW'(0));

    // Randomized traffic over a small tag space to force collisions
    for (int n = 0; n < 2000; n++) begin
      idle();
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 2) != 0) save(TW'($urandom_range(1, 7)), $urandom);
      if ($urandom_range(0, 1) != 0) restore(TW'($urandom_range(1, 7)));
      if ($urandom_range(0, 3) == 0) free(TW'($urandom_range(1, 7)));
      step();
    end
    rst_n = 1'b1;
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
